// File: rtl/tree_feature_sequencer.sv
// Byte-serial front end for the combinational decision-tree classifier: gathers one
// sample of NUM_FEAT features, lets the tree settle, then holds the class on a valid/ready port.
module tree_feature_sequencer #(
   parameter int NUM_FEAT   = 18,
   parameter int FEAT_W     = 8,
   parameter int CLASS_W    = 2,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [FEAT_W-1:0]          in_data,
   input  logic                       in_last,
   output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
   input  logic [CLASS_W-1:0]         tree_class,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CLASS_W-1:0]         out_class,
   output logic                       err_len,
   output logic [CNT_W-1:0]           sample_cnt
);

   localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FEAT - 1);
   localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

   state_e                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [3:0]                   settle_q, settle_d;
   logic [NUM_FEAT*FEAT_W-1:0]   feat_q, feat_d;
   logic [CLASS_W-1:0]           class_q, class_d;
   logic                         err_q, err_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         accept_s;

   // Handshakes are decoded from the state register only, so no input reaches an output combinationally.
   assign in_ready   = (state_q == ST_LOAD);
   assign out_valid  = (state_q == ST_HOLD);
   assign feat_bus   = feat_q;
   assign out_class  = class_q;
   assign err_len    = err_q;
   assign sample_cnt = cnt_q;
   assign accept_s   = in_valid & (state_q == ST_LOAD);

   // Next-state logic: byte capture, length checking, settle countdown and class hand-off.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      feat_d   = feat_q;
      class_d  = class_q;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      case (state_q)
         ST_LOAD: begin
            if (accept_s) begin
               feat_d[int'(idx_q)*FEAT_W +: FEAT_W] = in_data;
               if (idx_q == LAST_IDX) begin
                  idx_d = {IDX_W{1'b0}};
                  if (in_last) begin
                     state_d  = ST_SETTLE;
                     settle_d = SETTLE_LOAD;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (in_last) begin
                  // Short sample: dropped, stale slots are simply overwritten by the next one.
                  idx_d = {IDX_W{1'b0}};
                  err_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_SETTLE: begin
            if (settle_q == 4'd0) begin
               class_d = tree_class;
               state_d = ST_HOLD;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_LOAD;
               cnt_d   = cnt_q + CNT_W'(1);
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_LOAD;
            idx_d   = {IDX_W{1'b0}};
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_LOAD;
         idx_q    <= {IDX_W{1'b0}};
         settle_q <= 4'd0;
         feat_q   <= {(NUM_FEAT*FEAT_W){1'b0}};
         class_q  <= {CLASS_W{1'b0}};
         err_q    <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         feat_q   <= feat_d;
         class_q  <= class_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_tree_feature_sequencer.sv
// Directed bench for tree_feature_sequencer; a second instance with a 2-bit sample counter
// shares the stimulus so counter wrap-around can be observed.
module tb_tree_feature_sequencer;
   localparam int NF = 18;
   localparam int FW = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic [FW-1:0]       in_data;
   logic                in_last;
   logic [1:0]          tree_class;
   logic                out_ready;

   logic                in_ready,  in_ready_w;
   logic [NF*FW-1:0]    feat_bus,  feat_bus_w;
   logic                out_valid, out_valid_w;
   logic [1:0]          out_class, out_class_w;
   logic                err_len,   err_len_w;
   logic [15:0]         sample_cnt;
   logic [1:0]          sample_cnt_w;

   int checks = 0;
   int errors = 0;
   logic [FW-1:0] model [NF];

   tree_feature_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .feat_bus(feat_bus), .tree_class(tree_class),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
      .err_len(err_len), .sample_cnt(sample_cnt)
   );

   tree_feature_sequencer #(.CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_data(in_data), .in_last(in_last), .feat_bus(feat_bus_w), .tree_class(tree_class),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_class(out_class_w),
      .err_len(err_len_w), .sample_cnt(sample_cnt_w)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NF*FW-1:0] obs, input logic [NF*FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NF*FW-1:0] packm();
      logic [NF*FW-1:0] r;
      r = '0;
      for (int k = 0; k < NF; k++) r[k*FW +: FW] = model[k];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int slot, input logic [FW-1:0] d, input logic last);
      chk("in_ready_pre", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      model[slot] = d;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      out_ready = 1'b0; tree_class = 2'b00;
      for (int k = 0; k < NF; k++) model[k] = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_class", out_class, 2'b00);
      chk("rst_err_len", err_len, 1'b0);
      chk("rst_sample_cnt", sample_cnt, 16'd0);
      chk("rst_feat_bus", feat_bus, packm());

      // Partial sample, then asynchronous reset mid-LOAD
      for (int k = 0; k < 5; k++) send(k, 8'hA0 + 8'(k), 1'b0);
      chk("partial_feat", feat_bus, packm());
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NF; k++) model[k] = 8'h00;
      chk("arst_feat_bus", feat_bus, packm());
      chk("arst_in_ready", in_ready, 1'b1);
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_err_len", err_len, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      // Sample 1: slot k = k, settle latency, backpressure in SETTLE/HOLD
      tree_class = 2'b10;
      for (int k = 0; k < NF; k++) send(k, 8'(k), k == NF - 1);
      chk("s1_feat", feat_bus, packm());
      chk("s1_in_ready_settle", in_ready, 1'b0);
      chk("s1_out_valid_e0", out_valid, 1'b0);
      in_valid = 1'b1; in_data = 8'hFF;
      tick();
      chk("s1_out_valid_e1", out_valid, 1'b0);
      chk("s1_feat_settle", feat_bus, packm());
      tick();
      chk("s1_out_valid_e2", out_valid, 1'b1);
      chk("s1_out_class", out_class, 2'b10);
      chk("s1_in_ready_hold", in_ready, 1'b0);
      for (int c = 0; c < 7; c++) begin
         tick();
         chk("s1_hold_valid", out_valid, 1'b1);
         chk("s1_hold_class", out_class, 2'b10);
         chk("s1_hold_feat", feat_bus, packm());
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("s1_done_valid", out_valid, 1'b0);
      chk("s1_done_in_ready", in_ready, 1'b1);
      chk("s1_cnt", sample_cnt, 16'd1);
      chk("s1_cnt_w", sample_cnt_w, 2'd1);

      // Sample 2: nominal, out_ready held high
      out_ready = 1'b1;
      for (int k = 0; k < NF; k++) send(k, 8'h40 + 8'(k), k == NF - 1);
      chk("s2_feat", feat_bus, packm());
      tick();
      chk("s2_out_valid_e1", out_valid, 1'b0);
      tick();
      chk("s2_out_valid_e2", out_valid, 1'b1);
      chk("s2_out_class", out_class, 2'b10);
      tick();
      chk("s2_out_valid_e3", out_valid, 1'b0);
      chk("s2_cnt", sample_cnt, 16'd2);
      chk("s2_cnt_w", sample_cnt_w, 2'd2);
      out_ready = 1'b0;

      // Length error: in_last on byte 10
      for (int k = 0; k < 10; k++) send(k, 8'h80 + 8'(k), k == 9);
      chk("short_err", err_len, 1'b1);
      chk("short_in_ready", in_ready, 1'b1);
      chk("short_feat", feat_bus, packm());
      tick();
      chk("short_err_clear", err_len, 1'b0);
      chk("short_no_valid", out_valid, 1'b0);

      // Length error: 18th byte without in_last
      for (int k = 0; k < NF; k++) send(k, 8'hC0 + 8'(k), 1'b0);
      chk("long_err", err_len, 1'b1);
      chk("long_feat", feat_bus, packm());
      tick();
      chk("long_err_clear", err_len, 1'b0);
      chk("long_no_valid", out_valid, 1'b0);

      // Sample 3: tree_class changes one cycle before capture, and again after
      tree_class = 2'b01;
      for (int k = 0; k < NF; k++) send(k, 8'h20 + 8'(k), k == NF - 1);
      chk("s3_err_none", err_len, 1'b0);
      tick();
      chk("s3_out_valid_e1", out_valid, 1'b0);
      tree_class = 2'b11;
      tick();
      chk("s3_out_valid_e2", out_valid, 1'b1);
      chk("s3_out_class", out_class, 2'b11);
      tree_class = 2'b00;
      tick();
      chk("s3_class_stable", out_class, 2'b11);
      chk("s3_valid_stable", out_valid, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("s3_cnt", sample_cnt, 16'd3);
      chk("s3_cnt_w", sample_cnt_w, 2'd3);

      // Samples 4 and 5: counter wrap on the 2-bit instance
      for (int s = 4; s <= 5; s++) begin
         tree_class = 2'(s);
         out_ready  = 1'b1;
         for (int k = 0; k < NF; k++) send(k, 8'(s * 16 + k), k == NF - 1);
         tick();
         tick();
         chk("sN_out_valid", out_valid, 1'b1);
         chk("sN_out_class", out_class, 2'(s));
         tick();
         chk("sN_cnt", sample_cnt, 16'(s));
         chk("sN_cnt_w", sample_cnt_w, 2'(s));
         out_ready = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tree_feature_sequencer.md
# tree_feature_sequencer

Front-end controller for the combinational decision-tree classifier. It accepts one sample as a byte-serial stream of NUM_FEAT 8-bit features, holds them on a parallel bus driving the tree's feature inputs, and waits a fixed settle interval for the tree to resolve. It then captures the class and presents it on a valid/ready output. This reduces classifier I/O from NUM_FEAT×8 pins to one byte lane plus handshakes.

## Interface
- NUM_FEAT, 18: features per sample; slot k drives tree feature k.
- FEAT_W, 8: feature width.
- CLASS_W, 2: class width.
- SETTLE_CYC, 2: cycles allowed for the tree to settle; legal range 1..15.
- CNT_W, 16: width of the sample counter.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte on in_data is valid.
- in_ready  out  1  sequencer accepts a byte.
- in_data  in  FEAT_W  feature byte.
- in_last  in  1  marks the final byte of a sample.
- feat_bus  out  NUM_FEAT*FEAT_W  registered features to the tree; slot k at bits [k*FEAT_W +: FEAT_W].
- tree_class  in  CLASS_W  class output of the combinational tree.
- out_valid  out  1  out_class is valid.
- out_ready  in  1  consumer accepts the class.
- out_class  out  CLASS_W  captured class.
- err_len  out  1  one-cycle pulse: sample length mismatch.
- sample_cnt  out  CNT_W  number of classified samples delivered, wraps.

## Operation
- States: LOAD, SETTLE, HOLD. The reset state is LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted byte (in_valid & in_ready) is written to slot idx, then idx increments.
  - idx range is 0..NUM_FEAT-1.
- On an accepted byte, the next action depends on idx and in_last:
  - idx==NUM_FEAT-1 and in_last=1: go to SETTLE, set idx=0, load settle counter.
  - idx==NUM_FEAT-1 and in_last=0: pulse err_len, set idx=0, stay in LOAD. The sample is dropped.
  - idx<NUM_FEAT-1 and in_last=1: pulse err_len, set idx=0, stay in LOAD. The sample is dropped.
- On a dropped sample, slot contents are not cleared. The next sample overwrites them.
- SETTLE:
  - in_ready=0.
  - feat_bus is frozen.
  - The counter runs for SETTLE_CYC cycles.
  - On the edge ending the last settle cycle: out_class<=tree_class, out_valid<=1, go to HOLD.
- HOLD:
  - out_valid=1, in_ready=0.
  - out_class and feat_bus are stable.
  - On out_valid & out_ready: out_valid<=0, sample_cnt<=sample_cnt+1 (mod 2^CNT_W), go to LOAD.
- feat_bus changes only on accepted bytes in LOAD.
- in_ready and out_valid are never both 1.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - state=LOAD, in_ready=1.
  - feat_bus=0, idx=0.
  - out_valid=0, out_class=0.
  - err_len=0, sample_cnt=0.
- All outputs are registered or decoded directly from the state register. No combinational path from in_valid or out_ready to any output.
- Throughput: one byte per cycle in LOAD.
- Latency:
  - Final byte accepted at edge E0.
  - out_valid rises at edge E0+SETTLE_CYC.
  - tree_class is sampled at that edge only.
- Handshake completion at edge Eh gives in_ready=1 from Eh. The next sample's first byte can be accepted at Eh+1.
- Minimum sample period: NUM_FEAT + SETTLE_CYC + 1 cycles.
- err_len goes high for exactly the one cycle after the offending accept edge.
- Bytes presented while in_ready=0 are ignored, not buffered. The upstream must hold them.
- out_valid, once high, stays high with out_class unchanged until accepted.
- If rst_n falls in any state, the partial sample or pending class is discarded. After rst_n rises, the first accepted byte goes to slot 0.

## Test plan
- Reset then idle: rst_n low mid-LOAD after 5 bytes -> all outputs at reset values; next 18 bytes 0x00..0x11 with in_last on the 18th -> feat_bus slot k = k.
- Nominal: stream 18 bytes back-to-back with tree_class tied to 2'b10 and out_ready=1 -> out_valid high exactly 2 cycles after the final accept edge, for 1 cycle; out_class=2'b10; sample_cnt=1.
- Backpressure:
  - in_valid held during SETTLE/HOLD -> no slot changes.
  - out_ready low for 7 cycles -> out_valid and out_class stable for 7 cycles, then one handshake.
- Length errors:
  - in_last on byte 10 -> err_len 1-cycle pulse, no out_valid.
  - 18th byte without in_last -> err_len pulse.
  - Following correct sample -> classified normally.
- Settle sampling: tree_class changes from 2'b01 to 2'b11 one cycle before the capture edge (SETTLE_CYC=2) -> out_class=2'b11; a change after capture does not alter out_class.
- Counter wrap: CNT_W=2, 5 samples -> sample_cnt sequence 1,2,3,0,1.
